// File: rtl/ana_ctrl_pkg.sv
// ana_ctrl_pkg: shared types and sizing helpers for the analog tile control core.
//   seq_state_t  : channel sequencer states
//   cfg_bits()   : total serial configuration frame length in bits
//   idx_width()  : channel index width (at least 1 bit)
package ana_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    DWELL = 2'd2
  } seq_state_t;

  function automatic int unsigned cfg_bits(input int unsigned num_ch, input int unsigned trim_w);
    return num_ch * trim_w;
  endfunction

  function automatic int unsigned idx_width(input int unsigned num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/ana_sync_edge.sv
// ana_sync_edge: multi-flop synchroniser for an asynchronous pin plus edge pulses.
//   clk, rst_n : system clock, synchronous active-low reset
//   d          : asynchronous input pin
//   level      : synchronised level (last synchroniser stage)
//   rise, fall : 1-cycle pulses, last stage compared with one extra flop
// All flops reset to RST_VAL so an idle pin produces no edge out of reset.
module ana_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/ana_trim_seq_ctrl.sv
// ana_trim_seq_ctrl: digital control core for the analog tile.
//   Serial port (sclk_i/sdi_i/csn_i, MSB first) loads NUM_CH*TRIM_W trim bits into a
//   shift register; a frame with exactly that many bits commits all trims at once to
//   trim_o, otherwise cfg_err_o is raised until the next frame starts. sdo_o is the
//   shift-register MSB.
//   Sequencer (run_i, ena, dwell_i) walks channels round-robin: one idle gap cycle,
//   then sel_o one-hot for max(dwell_i,1) cycles with settle_o on the last one.
//   ch_idx_o is the current/last channel, busy_o is high whenever not IDLE.
module ana_trim_seq_ctrl
  import ana_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned TRIM_W      = 6,
  parameter int unsigned DWELL_W     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ena,
  input  logic                              sclk_i,
  input  logic                              sdi_i,
  input  logic                              csn_i,
  output logic                              sdo_o,
  output logic                              cfg_err_o,
  output logic [NUM_CH*TRIM_W-1:0]          trim_o,
  input  logic                              run_i,
  input  logic [DWELL_W-1:0]                dwell_i,
  output logic [NUM_CH-1:0]                 sel_o,
  output logic [idx_width(NUM_CH)-1:0]      ch_idx_o,
  output logic                              settle_o,
  output logic                              busy_o
);

  localparam int unsigned CFG_W = cfg_bits(NUM_CH, TRIM_W);
  localparam int unsigned IDX_W = idx_width(NUM_CH);
  localparam int unsigned CNT_W = $clog2(CFG_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_W + 1);

  // ---------------- serial configuration port ----------------
  logic sclk_lvl, sclk_rise;
  logic csn_lvl, csn_rise, csn_fall;
  logic sdi_lvl;
  logic sclk_unused_fall, sdi_unused_rise, sdi_unused_fall;

  ana_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk_i),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_unused_fall)
  );

  ana_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk(clk), .rst_n(rst_n), .d(sdi_i),
    .level(sdi_lvl), .rise(sdi_unused_rise), .fall(sdi_unused_fall)
  );

  ana_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .clk(clk), .rst_n(rst_n), .d(csn_i),
    .level(csn_lvl), .rise(csn_rise), .fall(csn_fall)
  );

  logic [CFG_W-1:0] sr_q, sr_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_base, cnt_nxt;
  logic             shift_en;
  logic             commit_q;

  // A sclk rise coincident with the csn rise still belongs to the frame, so the
  // shift happens first and the commit decision uses the post-shift count.
  assign shift_en = sclk_rise & (~csn_lvl | csn_rise);

  always_comb begin
    sr_nxt   = sr_q;
    cnt_base = csn_fall ? '0 : cnt_q;
    cnt_nxt  = cnt_base;
    if (shift_en) begin
      sr_nxt = {sr_q[CFG_W-2:0], sdi_lvl};
      if (cnt_base != CNT_SAT) cnt_nxt = cnt_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      commit_q  <= 1'b0;
      cfg_err_o <= 1'b0;
      trim_o    <= '0;
    end else begin
      sr_q     <= sr_nxt;
      cnt_q    <= cnt_nxt;
      commit_q <= csn_rise && (cnt_nxt == CNT_FULL);
      if (csn_fall)
        cfg_err_o <= 1'b0;
      else if (csn_rise && (cnt_nxt != CNT_FULL))
        cfg_err_o <= 1'b1;
      if (commit_q) trim_o <= sr_q;
    end
  end

  assign sdo_o = sr_q[CFG_W-1];

  // ---------------- channel sequencer ----------------
  seq_state_t         state_q, state_nxt;
  logic [DWELL_W-1:0] dcnt_q, dcnt_nxt;
  logic [IDX_W-1:0]   idx_q, idx_nxt;
  logic [NUM_CH-1:0]  sel_nxt;
  logic               settle_nxt, busy_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dcnt_q   <= '0;
      idx_q    <= '0;
      sel_o    <= '0;
      settle_o <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      dcnt_q   <= dcnt_nxt;
      idx_q    <= idx_nxt;
      sel_o    <= sel_nxt;
      settle_o <= settle_nxt;
      busy_o   <= busy_nxt;
    end
  end

  // Outputs are registered from the next-state values so they line up with the
  // state they describe rather than lagging it by a cycle.
  always_comb begin
    state_nxt = state_q;
    dcnt_nxt  = dcnt_q;
    idx_nxt   = idx_q;
    if (!(run_i && ena)) begin
      state_nxt = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_nxt = GAP;
          idx_nxt   = '0;
        end
        GAP: begin
          state_nxt = DWELL;
          dcnt_nxt  = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
        end
        DWELL: begin
          if (dcnt_q <= DWELL_W'(1)) begin
            state_nxt = GAP;
            idx_nxt   = (idx_q == IDX_W'(NUM_CH - 1)) ? '0 : idx_q + IDX_W'(1);
          end else begin
            dcnt_nxt = dcnt_q - DWELL_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    sel_nxt    = (state_nxt == DWELL) ? (NUM_CH'(1) << idx_nxt) : '0;
    settle_nxt = (state_nxt == DWELL) && (dcnt_nxt == DWELL_W'(1));
    busy_nxt   = (state_nxt != IDLE);
  end

  assign ch_idx_o = idx_q;

endmodule

// File: tb/tb_ana_trim_seq_ctrl.sv
// tb_ana_trim_seq_ctrl: scoreboard bench for ana_trim_seq_ctrl (NUM_CH=4, TRIM_W=6).
`timescale 1ns/1ps
module tb_ana_trim_seq_ctrl;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned TRIM_W  = 6;
  localparam int unsigned DWELL_W = 8;
  localparam int unsigned SYNC    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        sclk_i = 1'b0;
  logic        sdi_i = 1'b0;
  logic        csn_i = 1'b1;
  logic        sdo_o;
  logic        cfg_err_o;
  logic [23:0] trim_o;
  logic        run_i = 1'b0;
  logic [7:0]  dwell_i = 8'd0;
  logic [3:0]  sel_o;
  logic [1:0]  ch_idx_o;
  logic        settle_o;
  logic        busy_o;

  always #5 clk = ~clk;

  ana_trim_seq_ctrl #(
    .NUM_CH(NUM_CH), .TRIM_W(TRIM_W), .DWELL_W(DWELL_W), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .sclk_i(sclk_i), .sdi_i(sdi_i), .csn_i(csn_i),
    .sdo_o(sdo_o), .cfg_err_o(cfg_err_o), .trim_o(trim_o),
    .run_i(run_i), .dwell_i(dwell_i),
    .sel_o(sel_o), .ch_idx_o(ch_idx_o), .settle_o(settle_o), .busy_o(busy_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboards ----------------
  typedef struct packed {
    logic [3:0] sel;
    logic       settle;
    logic [1:0] idx;
  } seq_exp_t;

  typedef struct packed {
    logic [23:0] trim;
    logic        err;
  } frm_exp_t;

  seq_exp_t seq_q[$];
  frm_exp_t frm_q[$];

  // Sequencer monitor: every cycle the DUT reports busy is one expected entry.
  seq_exp_t se;
  always @(negedge clk) begin
    if (busy_o === 1'b1) begin
      if (seq_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL seq_unexpected_busy: got sel %0h settle %0b expected idle at %0t",
                 sel_o, settle_o, $time);
      end else begin
        se = seq_q.pop_front();
        check("seq_sel", {28'd0, sel_o}, {28'd0, se.sel});
        check("seq_settle", {31'd0, settle_o}, {31'd0, se.settle});
        check("seq_idx", {30'd0, ch_idx_o}, {30'd0, se.idx});
      end
    end
  end

  // Frame monitor: judges the result a fixed number of cycles after each csn rise.
  frm_exp_t fe;
  initial begin
    @(posedge rst_n);
    forever begin
      @(posedge csn_i);
      repeat (6) @(posedge clk);
      @(negedge clk);
      if (frm_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL frm_unexpected: got trim %0h err %0b expected no frame", trim_o, cfg_err_o);
      end else begin
        fe = frm_q.pop_front();
        check("frm_trim", {8'd0, trim_o}, {8'd0, fe.trim});
        check("frm_err", {31'd0, cfg_err_o}, {31'd0, fe.err});
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send_frame(input logic [31:0] data, input int nbits,
                            input logic [23:0] exp_trim, input logic exp_err);
    frm_exp_t f;
    @(posedge clk); #1 csn_i = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("err_clear_on_csn_fall", {31'd0, cfg_err_o}, 32'd0);
    for (int i = nbits - 1; i >= 0; i--) begin
      @(posedge clk); #1 sdi_i = data[i];
      repeat (3) @(posedge clk);
      #1 sclk_i = 1'b1;
      repeat (3) @(posedge clk);
      #1 sclk_i = 1'b0;
    end
    repeat (3) @(posedge clk);
    f.trim = exp_trim;
    f.err  = exp_err;
    frm_q.push_back(f);
    #1 csn_i = 1'b1;
    repeat (10) @(posedge clk);
    if (nbits >= 24) begin
      @(negedge clk);
      check("sdo_msb", {31'd0, sdo_o}, {31'd0, data[23]});
    end
  endtask

  // stop_mode: 0 = drop run_i, 1 = drop ena, 2 = assert reset
  task automatic run_seq(input int dwell, input int ncyc, input int stop_mode);
    int eff, per, pos, k;
    seq_exp_t e;
    eff = (dwell == 0) ? 1 : dwell;
    per = eff + 1;
    for (int c = 0; c < ncyc; c++) begin
      pos = c % per;
      k   = (c / per) % 4;
      e.idx    = 2'(k);
      e.sel    = (pos == 0) ? 4'b0000 : 4'(1 << k);
      e.settle = (pos == eff);
      seq_q.push_back(e);
    end
    @(posedge clk); #1;
    dwell_i = 8'(dwell);
    run_i   = 1'b1;
    repeat (ncyc) @(posedge clk);
    #1;
    case (stop_mode)
      0: run_i = 1'b0;
      1: ena = 1'b0;
      default: begin
        rst_n = 1'b0;
        run_i = 1'b0;
      end
    endcase
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("stop_sel", {28'd0, sel_o}, 32'd0);
    check("stop_busy", {31'd0, busy_o}, 32'd0);
    check("stop_settle", {31'd0, settle_o}, 32'd0);
    check("seq_q_drained", seq_q.size(), 32'd0);
    if (stop_mode == 2) begin
      check("rst_trim", {8'd0, trim_o}, 32'd0);
      check("rst_idx", {30'd0, ch_idx_o}, 32'd0);
      check("rst_sdo", {31'd0, sdo_o}, 32'd0);
      check("rst_err", {31'd0, cfg_err_o}, 32'd0);
      #1 rst_n = 1'b1;
    end
    run_i = 1'b0;
    ena   = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_trim", {8'd0, trim_o}, 32'd0);
    check("reset_sel", {28'd0, sel_o}, 32'd0);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_settle", {31'd0, settle_o}, 32'd0);
    check("reset_idx", {30'd0, ch_idx_o}, 32'd0);
    check("reset_sdo", {31'd0, sdo_o}, 32'd0);
    check("reset_err", {31'd0, cfg_err_o}, 32'd0);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // full frame, short frame, good frame again, long frame
    send_frame(32'hABCDEF, 24, 24'hABCDEF, 1'b0);
    send_frame(32'h091A2B, 23, 24'hABCDEF, 1'b1);
    send_frame(32'h123456, 24, 24'h123456, 1'b0);
    send_frame(32'h1555555, 25, 24'h123456, 1'b1);

    // round-robin with dwell 3, two full laps plus a gap
    run_seq(3, 33, 0);
    // dwell 0 behaves as 1
    run_seq(0, 9, 0);
    // abort mid-dwell by run_i
    run_seq(5, 3, 0);

    // ena drop mid-dwell while a frame is loaded concurrently
    fork
      send_frame(32'h0F0F0F, 24, 24'h0F0F0F, 1'b0);
      run_seq(3, 30, 1);
    join

    // reset in the middle of a sequence
    run_seq(3, 10, 2);

    check("frm_q_drained", frm_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got no completion expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

endmodule
